// File: rtl/uncache_store_buffer_pkg.sv
// Shared definitions for the uncache store buffer and the bridge-side uncache port:
// FSM state encoding and the layout of one posted-write entry.
package uncache_store_buffer_pkg;

   localparam int WEN_W   = 4;
   localparam int ADDR_W  = 32;
   localparam int WDATA_W = 32;
   localparam int ENTRY_W = WEN_W + ADDR_W + WDATA_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_WAIT = 2'd1,
      RD_WAIT = 2'd2,
      RD_DONE = 2'd3
   } state_e;

   typedef struct packed {
      logic [WEN_W-1:0]   wen;
      logic [ADDR_W-1:0]  addr;
      logic [WDATA_W-1:0] wdata;
   } entry_t;

endpackage

// File: rtl/uncache_store_buffer_sync_fifo.sv
// Power-of-two synchronous FIFO with combinational head and head+1 read ports.
// Pointers wrap naturally at DEPTH; the storage array is not reset.
module sync_fifo
   import uncache_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = ENTRY_W,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [WIDTH-1:0] next_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] rd_nxt;
   logic [PTR_W:0]   count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rd_nxt  = rd_ptr_q + 1'b1;
   assign head_o  = mem_q[rd_ptr_q];
   assign next_o  = mem_q[rd_nxt];

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_nxt;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uncache_store_buffer.sv
// Posted-write buffer in front of the bridge uncache port: stores queue and drain in order,
// loads stall until every queued store has completed and then issue as a single read.
module uncache_store_buffer
   import uncache_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        cpu_req,
   input  logic [3:0]  cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_stall,
   output logic        cpu_rvalid,
   output logic [31:0] cpu_rdata,
   output logic        uncache_en,
   output logic [3:0]  uncache_wen,
   output logic [31:0] uncache_addr,
   output logic [31:0] uncache_wdata,
   input  logic [31:0] uncache_rdata,
   input  logic        uncache_refresh
);

   state_e         state_q, state_d;
   logic           en_q, en_d;
   logic [3:0]     wen_q, wen_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           rvalid_q, rvalid_d;
   logic [31:0]    rdata_q, rdata_d;

   entry_t         in_entry, head, nxt;
   logic           is_store, store_acc, load_req, pop;
   logic           fifo_full, fifo_empty;
   logic [PTR_W:0] fifo_cnt;

   assign in_entry  = {cpu_wen, cpu_addr, cpu_wdata};
   assign is_store  = |cpu_wen;
   assign store_acc = cpu_req & is_store & ~fifo_full;
   assign load_req  = cpu_req & ~is_store;
   assign pop       = (state_q == WR_WAIT) & uncache_refresh;

   // A full FIFO stalls stores even when a pop lands on the same edge, keeping stall off refresh.
   assign cpu_stall = cpu_req & (is_store ? fifo_full : (state_q != RD_DONE));

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (store_acc),
      .wdata_i (in_entry),
      .pop_i   (pop),
      .head_o  (head),
      .next_o  (nxt),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      wen_d    = wen_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               {wen_d, addr_d, wdata_d} = head;
               en_d    = 1'b1;
               state_d = WR_WAIT;
            end else if (store_acc) begin
               // Empty FIFO: present the incoming store directly; it is still pushed and popped later.
               {wen_d, addr_d, wdata_d} = in_entry;
               en_d    = 1'b1;
               state_d = WR_WAIT;
            end else if (load_req) begin
               en_d    = 1'b1;
               wen_d   = 4'b0000;
               addr_d  = cpu_addr;
               state_d = RD_WAIT;
            end
         end
         WR_WAIT: begin
            if (uncache_refresh) begin
               if (fifo_cnt > (PTR_W+1)'(1)) begin
                  {wen_d, addr_d, wdata_d} = nxt;
               end else begin
                  en_d    = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         RD_WAIT: begin
            if (uncache_refresh) begin
               rdata_d  = uncache_rdata;
               rvalid_d = 1'b1;
               en_d     = 1'b0;
               state_d  = RD_DONE;
            end
         end
         RD_DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         en_q     <= 1'b0;
         wen_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         en_q     <= en_d;
         wen_q    <= wen_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign uncache_en    = en_q;
   assign uncache_wen   = wen_q;
   assign uncache_addr  = addr_q;
   assign uncache_wdata = wdata_q;
   assign cpu_rvalid    = rvalid_q;
   assign cpu_rdata     = rdata_q;

endmodule

// File: tb/tb_uncache_store_buffer.sv
// Bench for uncache_store_buffer: bridge responder, transaction-level model, per-cycle compare.
module tb_uncache_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        cpu_req;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_stall;
   logic        cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        uncache_en;
   logic [3:0]  uncache_wen;
   logic [31:0] uncache_addr;
   logic [31:0] uncache_wdata;
   logic [31:0] uncache_rdata;
   logic        uncache_refresh;

   uncache_store_buffer #(.DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .cpu_req         (cpu_req),
      .cpu_wen         (cpu_wen),
      .cpu_addr        (cpu_addr),
      .cpu_wdata       (cpu_wdata),
      .cpu_stall       (cpu_stall),
      .cpu_rvalid      (cpu_rvalid),
      .cpu_rdata       (cpu_rdata),
      .uncache_en      (uncache_en),
      .uncache_wen     (uncache_wen),
      .uncache_addr    (uncache_addr),
      .uncache_wdata   (uncache_wdata),
      .uncache_rdata   (uncache_rdata),
      .uncache_refresh (uncache_refresh)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   int checks = 0;
   int errors = 0;

   // Model state: program-order store queue, occupancy, bridge responder.
   txn_t        exp_q[$];
   int          m_cnt = 0;
   bit          br_busy = 0;
   int          br_cnt = 0;
   txn_t        br_req;
   int          br_lat = 3;
   logic [31:0] br_rdata_val = 32'h0;
   int          n_writes = 0;
   int          n_reads = 0;
   bit          rd_done = 0;
   logic [31:0] exp_rdata = 32'h0;
   bit          exp_en_next = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Bridge: samples a request only when idle, completes with a one-cycle refresh after br_lat edges.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         exp_q.delete();
         m_cnt           = 0;
         br_busy         = 0;
         rd_done         = 0;
         exp_en_next     = 0;
         uncache_refresh <= 1'b0;
         uncache_rdata   <= 32'h0;
      end else begin
         bit   acc;
         bit   wpop;
         txn_t t;
         acc         = cpu_req && (cpu_wen != 4'b0000) && (m_cnt < DEPTH);
         wpop        = 0;
         rd_done     = 0;
         exp_en_next = 0;
         if (uncache_refresh) begin
            br_busy = 0;
            uncache_refresh <= 1'b0;
            if (br_req.wen != 4'b0000) begin
               wpop = 1;
               if (m_cnt > 1) exp_en_next = 1;
            end else begin
               rd_done   = 1;
               exp_rdata = br_rdata_val;
            end
         end else if (br_busy) begin
            br_cnt--;
            if (br_cnt == 0) begin
               uncache_refresh <= 1'b1;
               uncache_rdata   <= (br_req.wen == 4'b0000) ? br_rdata_val : 32'h0;
            end
         end else if (uncache_en) begin
            br_req.wen   = uncache_wen;
            br_req.addr  = uncache_addr;
            br_req.wdata = uncache_wdata;
            br_busy      = 1;
            br_cnt       = br_lat;
            if (uncache_wen != 4'b0000) begin
               n_writes++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL wr_unexpected addr=%h required=no_write", uncache_addr);
               end else begin
                  t = exp_q.pop_front();
                  chk("wr_addr", uncache_addr, t.addr);
                  chk("wr_wen", 32'(uncache_wen), 32'(t.wen));
                  chk("wr_wdata", uncache_wdata, t.wdata);
               end
            end else begin
               n_reads++;
               chk("rd_after_drain", 32'(m_cnt), 32'd0);
               chk("rd_addr", uncache_addr, cpu_addr);
            end
         end
         if (acc) begin
            t.wen   = cpu_wen;
            t.addr  = cpu_addr;
            t.wdata = cpu_wdata;
            exp_q.push_back(t);
         end
         m_cnt = m_cnt + (acc ? 1 : 0) - (wpop ? 1 : 0);
      end
   end

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      if (rstn) begin
         bit exp_stall;
         exp_stall = cpu_req && ((cpu_wen != 4'b0000) ? (m_cnt == DEPTH) : !rd_done);
         chk("stall", 32'(cpu_stall), 32'(exp_stall));
         chk("rvalid", 32'(cpu_rvalid), 32'(rd_done));
         if (rd_done) chk("rdata", cpu_rdata, exp_rdata);
         chk("count", 32'(dut.fifo_cnt), 32'(m_cnt));
         if (exp_en_next) chk("en_b2b", 32'(uncache_en), 32'd1);
         if (br_busy) begin
            chk("hold_en", 32'(uncache_en), 32'd1);
            chk("hold_wen", 32'(uncache_wen), 32'(br_req.wen));
            chk("hold_addr", uncache_addr, br_req.addr);
            chk("hold_wdata", uncache_wdata, br_req.wdata);
         end
      end
   end

   task automatic store(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        output int waited);
      cpu_req   = 1'b1;
      cpu_wen   = w;
      cpu_addr  = a;
      cpu_wdata = d;
      waited    = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!cpu_stall) break;
         waited++;
      end
      if (waited >= 200) begin
         checks++;
         errors++;
         $display("FAIL store_timeout addr=%h stalled=%0d cycles", a, waited);
      end
      @(posedge clk);
      #2;
      cpu_req = 1'b0;
      cpu_wen = 4'b0000;
   endtask

   task automatic load(input logic [31:0] a, output int waited);
      cpu_req  = 1'b1;
      cpu_wen  = 4'b0000;
      cpu_addr = a;
      waited   = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!cpu_stall) break;
         waited++;
      end
      if (waited >= 500) begin
         checks++;
         errors++;
         $display("FAIL load_timeout addr=%h stalled=%0d cycles", a, waited);
      end
      @(posedge clk);
      #2;
      cpu_req = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((m_cnt != 0 || br_busy) && n < 500) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout count=%0d required=0", m_cnt);
      end
      repeat (2) @(posedge clk);
      #2;
   endtask

   initial begin
      int w;
      int ws[5];
      int base;
      cpu_req   = 1'b0;
      cpu_wen   = 4'b0000;
      cpu_addr  = 32'h0;
      cpu_wdata = 32'h0;
      #1 rstn = 1'b0;
      #1;
      chk("rst_en", 32'(uncache_en), 32'd0);
      chk("rst_wen", 32'(uncache_wen), 32'd0);
      chk("rst_addr", uncache_addr, 32'h0);
      chk("rst_wdata", uncache_wdata, 32'h0);
      chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_count", 32'(dut.fifo_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #2;

      // Single store, visible on the bridge one cycle after acceptance.
      br_lat = 5;
      store(4'b1111, 32'hBFAF_F000, 32'h1234_5678, w);
      chk("s1_wait", 32'(w), 32'd0);
      chk("s1_en", 32'(uncache_en), 32'd1);
      chk("s1_wen", 32'(uncache_wen), 32'hF);
      chk("s1_addr", uncache_addr, 32'hBFAF_F000);
      chk("s1_wdata", uncache_wdata, 32'h1234_5678);
      drain();
      chk("s1_en_off", 32'(uncache_en), 32'd0);
      chk("s1_count", 32'(dut.fifo_cnt), 32'd0);
      chk("s1_nwr", 32'(n_writes), 32'd1);

      // Burst of five: four fit, the fifth waits for the first pop.
      br_lat = 2;
      for (int i = 0; i < 5; i++)
         store(4'b1111, 32'h1000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), ws[i]);
      for (int i = 0; i < 4; i++) chk("burst_nowait", 32'(ws[i]), 32'd0);
      chk("burst5_stalled", 32'(ws[4] > 0), 32'd1);
      drain();
      chk("burst_nwr", 32'(n_writes), 32'd6);

      // Load behind two queued stores.
      br_lat       = 3;
      br_rdata_val = 32'hDEAD_BEEF;
      store(4'b1111, 32'hBFD0_0010, 32'h0000_0011, w);
      store(4'b0011, 32'hBFD0_0014, 32'h0000_2222, w);
      load(32'hBFD0_1000, w);
      chk("ld_stalled", 32'(w > 8), 32'd1);
      chk("ld_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("ld_nwr", 32'(n_writes), 32'd8);
      repeat (6) @(posedge clk);
      #2;
      chk("ld_one_read", 32'(n_reads), 32'd1);
      chk("ld_rdata_hold", cpu_rdata, 32'hDEAD_BEEF);

      // Byte-lane store.
      store(4'b0100, 32'hBFD0_0002, 32'h00AB_0000, w);
      chk("byte_wen", 32'(uncache_wen), 32'h4);
      chk("byte_addr", uncache_addr, 32'hBFD0_0002);
      chk("byte_wdata", uncache_wdata, 32'h00AB_0000);
      drain();

      // Ten stores through a four-entry FIFO: pointers wrap twice.
      br_lat = 1;
      base   = n_writes;
      for (int i = 0; i < 10; i++)
         store(4'b1111, 32'h2000_0000 + 32'(i * 16), 32'h5500_0000 + 32'(i), w);
      drain();
      chk("wrap_nwr", 32'(n_writes - base), 32'd10);
      chk("wrap_count", 32'(dut.fifo_cnt), 32'd0);
      chk("wrap_qempty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset while three stores are outstanding.
      br_lat = 10;
      for (int i = 0; i < 3; i++)
         store(4'b1111, 32'h3000_0000 + 32'(i * 4), 32'h7700_0000 + 32'(i), w);
      chk("rst_pre_count", 32'(dut.fifo_cnt), 32'd3);
      #3 rstn = 1'b0;
      #1;
      chk("arst_en", 32'(uncache_en), 32'd0);
      chk("arst_count", 32'(dut.fifo_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      base = n_writes;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("post_rst_en", 32'(uncache_en), 32'd0);
      end
      chk("post_rst_nwr", 32'(n_writes - base), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
